shift_seq: RTL and testbench

- Multi-cycle shift/rotate sequencer for the RISC5 execute stage.
- Performs LSL, ASR, ROR and LSR on 32-bit operands.
- Processes the shift count in the same grouping as the combinational rotator: count bits [1:0], then [3:2], then bit 4. This replaces a full 32-bit barrel shifter with one small group-shift stage reused over three cycles.
- The CPU stalls on `busy` and consumes `res` on the `done` pulse.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/shift_step.sv | 38 +++
 rtl/shift_seq.sv | 105 ++++++++++
 tb/tb_shift_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: shift op codes, sequencer states and the
// single-step shift function used by the group-shift stage.
package cpu_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_LSR = 2'b11;

    localparam logic [1:0] SC_X1  = 2'd0;
    localparam logic [1:0] SC_X4  = 2'd1;
    localparam logic [1:0] SC_X16 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_1    = 2'd1,
        ST_2    = 2'd2,
        ST_3    = 2'd3
    } state_t;

    // Called only with constant k, so each call reduces to fixed wiring.
    function automatic logic [31:0] do_shift(input logic [31:0] x,
                                             input logic [1:0]  op,
                                             input logic [5:0]  k);
        logic [31:0] y;
        case (op)
            OP_LSL:  y = x << k;
            OP_ASR:  y = 32'($signed(x) >>> k);
            OP_ROR:  y = (x >> k) | (x << (6'd32 - k));
            default: y = x >> k;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One group-shift stage: shifts x by sel * {1,4,16} as a 4-way mux of
// fixed-distance shifts per scale.
module shift_step
    import cpu_pkg::*;
(
    input  logic [31:0] x,
    input  logic [1:0]  op,
    input  logic [1:0]  sel,
    input  logic [1:0]  scale,
    output logic [31:0] y
);

    logic [31:0] w_c1  [4];
    logic [31:0] w_c4  [4];
    logic [31:0] w_c16 [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_c14
            assign w_c1[gi] = do_shift(x, op, 6'(gi));
            assign w_c4[gi] = do_shift(x, op, 6'(4 * gi));
        end
        for (gi = 0; gi < 2; gi++) begin : g_c16
            assign w_c16[gi] = do_shift(x, op, 6'(16 * gi));
        end
    endgenerate

    // At x16 only count bit 4 is meaningful, carried in sel[0].
    always_comb begin
        y = x;
        case (scale)
            SC_X1:   y = w_c1[sel];
            SC_X4:   y = w_c4[sel];
            default: y = sel[0] ? w_c16[1] : w_c16[0];
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: applies count groups [1:0], [3:2], [4]
// over three cycles through one shift_step stage.
module shift_seq
    import cpu_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] value,
    input  logic [4:0]  shcnt,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    state_t      r_state, w_state_next;
    logic [31:0] r_acc,   w_acc_next;
    logic [4:0]  r_cnt,   w_cnt_next;
    logic [1:0]  r_op,    w_op_next;
    logic [31:0] r_res,   w_res_next;
    logic        r_done,  w_done_next;

    logic [1:0]  w_sel;
    logic [1:0]  w_scale;
    logic [31:0] w_step;

    shift_step u_step (
        .x     (r_acc),
        .op    (r_op),
        .sel   (w_sel),
        .scale (w_scale),
        .y     (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= OP_LSL;
            r_res   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_res   <= w_res_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        w_res_next   = r_res;
        w_done_next  = 1'b0;
        w_sel        = 2'd0;
        w_scale      = SC_X1;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (SKIP_ZERO && shcnt == 5'd0) begin
                        w_res_next  = value;
                        w_done_next = 1'b1;
                    end else begin
                        w_acc_next   = value;
                        w_cnt_next   = shcnt;
                        w_op_next    = op;
                        w_state_next = ST_1;
                    end
                end
            end
            ST_1: begin
                w_sel        = r_cnt[1:0];
                w_scale      = SC_X1;
                w_acc_next   = w_step;
                w_state_next = ST_2;
            end
            ST_2: begin
                w_sel        = r_cnt[3:2];
                w_scale      = SC_X4;
                w_acc_next   = w_step;
                w_state_next = ST_3;
            end
            default: begin
                w_sel        = {1'b0, r_cnt[4]};
                w_scale      = SC_X16;
                w_res_next   = w_step;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign res  = r_res;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: expected results are queued at issue and
// compared when done pulses; timing is checked inline per scenario.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] value = '0;
    logic [4:0]  shcnt = '0;
    logic        busy, done, busy0, done0;
    logic [31:0] res, res0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    shift_seq #(.SKIP_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .value(value),
        .shcnt(shcnt), .busy(busy), .done(done), .res(res)
    );

    shift_seq #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .value(value),
        .shcnt(shcnt), .busy(busy0), .done(done0), .res(res0)
    );

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v,
                                          input logic [4:0] n);
        logic [63:0] d;
        case (o)
            2'b00:   return v << n;
            2'b01:   return 32'($signed(v) >>> n);
            2'b10:   begin d = {v, v} >> n; return d[31:0]; end
            default: return v >> n;
        endcase
    endfunction

    // Scoreboard: every done of the SKIP_ZERO=1 instance consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: res=%h, no result expected", res);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (res !== e) begin
                    errors++;
                    $display("FAIL result: res=%h expected=%h", res, e);
                end else begin
                    $display("txn ok: res=%h", res);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] v,
                         input logic [4:0] n, input logic [31:0] e);
        start = 1'b1;
        op    = o;
        value = v;
        shcnt = n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
        shcnt = 5'($urandom);
        op    = 2'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, res} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b res=%h expected 0/0/0", busy, done, res);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ror();
        @(negedge clk);
        issue(2'b10, 32'h80000001, 5'd1, 32'hC0000000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== {1'(k <= 3), 1'(k == 4)}) begin
                errors++;
                $display("FAIL ror_timing T+%0d: busy=%b done=%b expected %b %b",
                         k, busy, done, k <= 3, k == 4);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || res !== 32'hC0000000) begin
            errors++;
            $display("FAIL ror_hold: done=%b res=%h expected 0 c0000000", done, res);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(2'b00, 32'h00000001, 5'd31, 32'h80000000);
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b expected 1", done);
        end
        issue(2'b01, 32'h80000000, 5'd4, 32'hF8000000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== {1'(k <= 3), 1'(k == 4)}) begin
                errors++;
                $display("FAIL b2b_second T+%0d: busy=%b done=%b", k, busy, done);
            end
        end
    endtask

    task automatic test_lsr_ror();
        logic [1:0]  ops[3]  = '{2'b11, 2'b10, 2'b10};
        logic [31:0] vals[3] = '{32'h80000000, 32'h12345678, 32'h00000002};
        logic [4:0]  cnts[3] = '{5'd4, 5'd16, 5'd31};
        logic [31:0] exps[3] = '{32'h08000000, 32'h56781234, 32'h00000004};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], vals[i], cnts[i], exps[i]);
            repeat (3) @(negedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL lsr_ror_done[%0d]: done=%b expected 1", i, done);
            end
        end
    endtask

    task automatic test_zero();
        logic busy_seen = 1'b0;
        @(negedge clk);
        issue(2'b00, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            busy_seen |= busy;
            checks++;
            if (done !== 1'(k == 1) || {busy0, done0} !== {1'(k <= 3), 1'(k == 4)}) begin
                errors++;
                $display("FAIL zero_timing T+%0d: done=%b busy0=%b done0=%b", k, done, busy0, done0);
            end
        end
        checks++;
        if (busy_seen !== 1'b0 || res0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL zero_result: busy_seen=%b res0=%h expected 0 deadbeef", busy_seen, res0);
        end
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        @(negedge clk);
        issue(2'b11, 32'hF0F0F0F0, 5'd8, 32'h00F0F0F0);
        @(negedge clk);
        n_done += int'(done);
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'hFFFFFFFF;
        shcnt = 5'd3;
        op    = 2'b00;
        @(negedge clk);
        n_done += int'(done);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            @(negedge clk);
            n_done += int'(done);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL ignored_start: done_count=%0d expected 1", n_done);
        end
    endtask

    task automatic test_random();
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  o;
            logic [31:0] v;
            logic [4:0]  n;
            o = 2'($urandom);
            v = $urandom;
            n = 5'($urandom_range(1, 31));
            issue(o, v, n, model(o, v, n));
            repeat (3) @(negedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL random_done[%0d]: done=%b expected 1", i, done);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int n_done = 0;
        @(negedge clk);
        issue(2'b10, 32'h12345678, 5'd16, 32'h56781234);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        checks++;
        if ({busy, done, res} !== 34'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b res=%h expected 0/0/0", busy, done, res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            n_done += int'(done);
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL post_reset_done: done_count=%0d expected 0", n_done);
        end
        issue(2'b01, 32'h80000001, 5'd1, 32'hC0000000);
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL recover_done: done=%b expected 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_ror();
        test_back_to_back();
        test_lsr_ror();
        test_zero();
        test_ignored_start();
        test_random();
        test_mid_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
